// File: rtl/terc.sv
// TERC: minimal 16-bit multi-cycle CPU core with no program counter.
// One instruction is taken from 'inst' every four clocks and walked through
// FETCH -> DECODE -> EXECUTE -> WRITEBACK against an 8-entry register file
// and a 256-word internal data RAM.

// Register file with two read ports and one write port; cleared on reset.
module RegFile #(
  parameter int WIDTH     = 16,
  parameter int REG_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic                 we,
  input  logic [REG_WIDTH-1:0] wSel,
  input  logic [WIDTH-1:0]     wData,
  input  logic [REG_WIDTH-1:0] lSel,
  input  logic [REG_WIDTH-1:0] rSel,
  output logic [WIDTH-1:0]     lData,
  output logic [WIDTH-1:0]     rData
);

  logic [WIDTH-1:0] ff [0:(1<<REG_WIDTH)-1];

  assign lData = ff[lSel];
  assign rData = ff[rSel];

  // Clear every register on reset, otherwise write the selected register.
  always_ff @(posedge clk) begin
    if (res) begin
      for (int i = 0; i < (1<<REG_WIDTH); i++) begin
        ff[i] <= '0;
      end
    end else if (we) begin
      ff[wSel] <= wData;
    end
  end

endmodule

module terc #(
  parameter int WIDTH     = 16,
  parameter int OP_WIDTH  = 4,
  parameter int REG_WIDTH = 3,
  parameter int IM_WIDTH  = 9,
  parameter int RAM_WIDTH = 8,
  parameter int CPU_CYCLE = 4
) (
  input  logic             clk,
  input  logic             res,
  input  logic [WIDTH-1:0] inst
);

  localparam int STATE_W = $clog2(CPU_CYCLE);

  localparam logic [OP_WIDTH-1:0] OP_NOP   = 4'h0;
  localparam logic [OP_WIDTH-1:0] OP_ADD   = 4'h1;
  localparam logic [OP_WIDTH-1:0] OP_SUB   = 4'h2;
  localparam logic [OP_WIDTH-1:0] OP_AND   = 4'h3;
  localparam logic [OP_WIDTH-1:0] OP_OR    = 4'h4;
  localparam logic [OP_WIDTH-1:0] OP_XOR   = 4'h5;
  localparam logic [OP_WIDTH-1:0] OP_LOADI = 4'h6;
  localparam logic [OP_WIDTH-1:0] OP_LOAD  = 4'h7;
  localparam logic [OP_WIDTH-1:0] OP_STORE = 4'h8;
  localparam logic [OP_WIDTH-1:0] OP_NOT   = 4'h9;
  localparam logic [OP_WIDTH-1:0] OP_SHL   = 4'hA;
  localparam logic [OP_WIDTH-1:0] OP_SHR   = 4'hB;

  typedef enum logic [STATE_W-1:0] {
    FETCH     = 2'd0,
    DECODE    = 2'd1,
    EXECUTE   = 2'd2,
    WRITEBACK = 2'd3
  } state_t;

  state_t               state;
  logic [WIDTH-1:0]     ir;
  logic [OP_WIDTH-1:0]  op;
  logic [REG_WIDTH-1:0] rd, rs, rt;
  logic [IM_WIDTH-1:0]  im;
  logic [REG_WIDTH-1:0] lSel, rSel, oSel;
  logic [WIDTH-1:0]     l, r, o;
  logic [RAM_WIDTH-1:0] a;
  logic [WIDTH-1:0]     lData, rData;
  logic [WIDTH-1:0]     mem [0:(1<<RAM_WIDTH)-1];

  logic OINdec, OINreg, LOUTdec, LOUTreg, ROUTdec, ROUTreg, CSdec, CSmem, RW;
  logic isRType;

  assign op = ir[WIDTH-1 -: OP_WIDTH];
  assign rd = ir[WIDTH-OP_WIDTH-1 -: REG_WIDTH];
  assign rs = ir[WIDTH-OP_WIDTH-REG_WIDTH-1 -: REG_WIDTH];
  assign rt = ir[WIDTH-OP_WIDTH-2*REG_WIDTH-1 -: REG_WIDTH];
  assign im = ir[IM_WIDTH-1:0];

  // Operand selection: STORE reads its address from rd and its data from rs.
  always_comb begin
    isRType = (op >= OP_ADD) && (op <= OP_XOR);
    lSel    = (op == OP_STORE) ? rd : rs;
    rSel    = (op == OP_STORE) ? rs : rt;
    oSel    = rd;
  end

  // Control strobes: decode-level intent, then qualified by the current state.
  always_comb begin
    OINdec  = ((op >= OP_ADD) && (op <= OP_LOAD)) || ((op >= OP_NOT) && (op <= OP_SHR));
    LOUTdec = OINdec && (op != OP_LOADI) || (op == OP_STORE);
    ROUTdec = isRType || (op == OP_STORE);
    CSdec   = (op == OP_LOAD) || (op == OP_STORE);
    OINreg  = OINdec && (state == WRITEBACK);
    LOUTreg = LOUTdec && (state == DECODE);
    ROUTreg = ROUTdec && (state == DECODE);
    CSmem   = CSdec && (((op == OP_LOAD) && (state == EXECUTE)) ||
                        ((op == OP_STORE) && (state == WRITEBACK)));
    RW      = !((op == OP_STORE) && (state == WRITEBACK));
  end

  RegFile #(.WIDTH(WIDTH), .REG_WIDTH(REG_WIDTH)) REG (
    .clk   (clk),
    .res   (res),
    .we    (OINreg),
    .wSel  (oSel),
    .wData (o),
    .lSel  (lSel),
    .rSel  (rSel),
    .lData (lData),
    .rData (rData)
  );

  // Four-phase sequencer holding the instruction and operand/result latches.
  always_ff @(posedge clk) begin
    if (res) begin
      state <= FETCH;
      ir    <= '0;
      l     <= '0;
      r     <= '0;
      o     <= '0;
      a     <= '0;
    end else begin
      case (state)
        FETCH: begin
          ir    <= inst;
          state <= DECODE;
        end
        DECODE: begin
          if (LOUTreg) l <= lData;
          if (ROUTreg) r <= rData;
          state <= EXECUTE;
        end
        EXECUTE: begin
          case (op)
            OP_ADD:   o <= l + r;
            OP_SUB:   o <= l - r;
            OP_AND:   o <= l & r;
            OP_OR:    o <= l | r;
            OP_XOR:   o <= l ^ r;
            OP_LOADI: o <= {{(WIDTH-IM_WIDTH){1'b0}}, im};
            OP_NOT:   o <= ~l;
            OP_SHL:   o <= l << 1;
            OP_SHR:   o <= l >> 1;
            OP_LOAD: begin
              a <= l[RAM_WIDTH-1:0];
              if (CSmem && RW) o <= mem[l[RAM_WIDTH-1:0]];
            end
            OP_STORE: a <= l[RAM_WIDTH-1:0];
            default: ;
          endcase
          state <= WRITEBACK;
        end
        WRITEBACK: begin
          state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

  // Data RAM write port; contents survive reset, an aborted store never lands.
  always_ff @(posedge clk) begin
    if (!res && CSmem && !RW) begin
      mem[a] <= r;
    end
  end

endmodule

// File: tb/tb_terc.sv
// Self-checking bench for terc: an ISA-level model predicts each instruction's
// architectural effect, queues it, and the queue is drained once the DUT has
// completed the instruction.
module tb_terc;

  logic        clk;
  logic        res;
  logic [15:0] inst;

  terc dut (
    .clk  (clk),
    .res  (res),
    .inst (inst)
  );

  typedef struct {
    string       tag;
    bit          isMem;
    int          idx;
    logic [15:0] val;
  } exp_t;

  exp_t        sbq[$];
  logic [15:0] regM [0:7];
  logic [15:0] memM [0:255];
  int          checks = 0;
  int          fails  = 0;

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rT(input logic [3:0] op, input int rd, input int rs, input int rt);
    return {op, 3'(rd), 3'(rs), 3'(rt), 3'b000};
  endfunction

  function automatic logic [15:0] iT(input int rd, input int im);
    return {4'h6, 3'(rd), 9'(im)};
  endfunction

  function automatic logic [15:0] mT(input logic [3:0] op, input int rd, input int rs);
    return {op, 3'(rd), 3'(rs), 6'b000000};
  endfunction

  // ISA model: update the reference state and queue the expected outcome.
  task automatic modelExec(input logic [15:0] ins);
    logic [3:0]  op;
    int          rd, rs, rt;
    logic [15:0] v;
    logic [7:0]  ad;
    bit          wr;
    op = ins[15:12];
    rd = int'(ins[11:9]);
    rs = int'(ins[8:6]);
    rt = int'(ins[5:3]);
    wr = 1'b1;
    v  = '0;
    case (op)
      4'h1: v = regM[rs] + regM[rt];
      4'h2: v = regM[rs] - regM[rt];
      4'h3: v = regM[rs] & regM[rt];
      4'h4: v = regM[rs] | regM[rt];
      4'h5: v = regM[rs] ^ regM[rt];
      4'h6: v = {7'b0, ins[8:0]};
      4'h7: v = memM[regM[rs][7:0]];
      4'h9: v = ~regM[rs];
      4'hA: v = {regM[rs][14:0], 1'b0};
      4'hB: v = {1'b0, regM[rs][15:1]};
      default: wr = 1'b0;
    endcase
    if (wr) begin
      regM[rd] = v;
      sbq.push_back('{$sformatf("op%h r%0d", op, rd), 1'b0, rd, v});
    end else if (op == 4'h8) begin
      ad = regM[rd][7:0];
      memM[ad] = regM[rs];
      sbq.push_back('{$sformatf("store mem[%h]", ad), 1'b1, int'(ad), regM[rs]});
    end else begin
      sbq.push_back('{"nop r0", 1'b0, 0, regM[0]});
    end
  endtask

  // Run one instruction aligned to FETCH, scribble on inst mid-flight,
  // then compare the queued expectation after the write-back edge.
  task automatic applyStimulus(input logic [15:0] ins);
    exp_t        e;
    logic [15:0] got;
    modelExec(ins);
    inst = ins;
    @(posedge clk);
    #1 inst = 16'h6FFF;
    repeat (3) @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      checkOutput("scoreboard empty", 16'h0000, 16'h0001);
    end else begin
      e   = sbq.pop_front();
      got = e.isMem ? dut.mem[e.idx[7:0]] : dut.REG.ff[e.idx[2:0]];
      checkOutput(e.tag, got, e.val);
    end
    checkOutput("state fetch", {14'b0, dut.state}, 16'h0000);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) regM[i] = '0;
    res  = 1'b1;
    inst = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset state", {14'b0, dut.state}, 16'h0000);
    for (int i = 0; i < 8; i++) checkOutput($sformatf("reset ff%0d", i), dut.REG.ff[i], 16'h0000);
    checkOutput("reset l", dut.l, 16'h0000);
    checkOutput("reset r", dut.r, 16'h0000);
    checkOutput("reset o", dut.o, 16'h0000);
    res = 1'b0;

    applyStimulus(16'h0000);
    checkOutput("nop l", dut.l, 16'h0000);
    checkOutput("nop o", dut.o, 16'h0000);

    applyStimulus(16'h6005);
    applyStimulus(16'h6A0E);
    checkOutput("loadi r0 const", dut.REG.ff[0], 16'h0005);
    checkOutput("loadi r5 const", dut.REG.ff[5], 16'h000E);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(iT(i, i));
      applyStimulus(iT(i + 4, 7 * i));
      applyStimulus(mT(4'h8, i, i + 4));
      applyStimulus(iT(i + 4, 0));
    end
    for (int i = 0; i < 4; i++) applyStimulus(mT(4'h7, i + 4, i));
    checkOutput("roundtrip r7 const", dut.REG.ff[7], 16'd21);
    checkOutput("roundtrip mem2 const", dut.mem[2], 16'd14);

    applyStimulus(iT(1, 9'h1FF));
    applyStimulus(iT(2, 1));
    applyStimulus(rT(4'h1, 3, 1, 2));
    checkOutput("add const", dut.REG.ff[3], 16'h0200);
    applyStimulus(rT(4'h2, 4, 2, 1));
    checkOutput("sub const", dut.REG.ff[4], 16'hFE02);
    applyStimulus(rT(4'h5, 5, 1, 2));
    applyStimulus(rT(4'h3, 6, 1, 2));
    applyStimulus(rT(4'h4, 7, 1, 2));
    applyStimulus(mT(4'h9, 3, 1));
    applyStimulus(mT(4'hA, 4, 1));
    applyStimulus(mT(4'hB, 5, 1));
    applyStimulus(16'hC000);

    for (int i = 0; i < 8; i++) applyStimulus(mT(4'hA, 1, 1));
    checkOutput("shl8 const", dut.REG.ff[1], 16'hFF00);

    applyStimulus(iT(1, 9'h105));
    applyStimulus(iT(2, 9'h055));
    applyStimulus(mT(4'h8, 1, 2));
    checkOutput("addr wrap const", dut.mem[5], 16'h0055);

    inst = iT(2, 9);
    @(posedge clk);
    #1 inst = 16'h0000;
    @(posedge clk);
    #1 res = 1'b1;
    @(posedge clk);
    #1 res = 1'b0;
    for (int i = 0; i < 8; i++) regM[i] = '0;
    checkOutput("abort r2", dut.REG.ff[2], 16'h0000);
    checkOutput("abort state", {14'b0, dut.state}, 16'h0000);
    applyStimulus(iT(1, 3));
    applyStimulus(mT(4'h7, 6, 1));
    checkOutput("ram kept const", dut.REG.ff[6], 16'd21);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/terc.md
Name: terc

Overview:
- terc is a minimal 16-bit multi-cycle CPU core with an 8-entry register file and a 256-word internal data RAM.
- It has no program counter. The instruction word is driven on input `inst` and executed once per 4-clock CPU cycle.
- It is the top of the TERC design. Verification observes architectural state through internal signals with fixed names (listed under Behaviour).

Parameters:
- WIDTH, 16, datapath and instruction width.
- OP_WIDTH, 4, opcode field width.
- REG_WIDTH, 3, register-select width (8 registers).
- IM_WIDTH, 9, immediate width.
- RAM_WIDTH, 8, RAM address width (256 words of WIDTH bits).
- CPU_CYCLE, 4, clocks per instruction.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- res  input  1  synchronous, active-high reset.
- inst  input  16  instruction word; sampled only in state FETCH.

Behaviour:
- Instruction formats, bit 15 is MSB:
  - R-type: op[15:12] rd[11:9] rs[8:6] rt[5:3] zero[2:0].
  - I-type: op[15:12] rd[11:9] im[8:0].
  - M-type: op[15:12] rd[11:9] rs[8:6] zero[5:0].
- Opcodes:
  - 0 NOP.
  - 1 ADD: rd=rs+rt.
  - 2 SUB: rd=rs-rt.
  - 3 AND, 4 OR, 5 XOR: bitwise, rd=rs op rt.
  - 6 LOADI: rd=zero-extended im.
  - 7 LOAD: rd=mem[rs[7:0]].
  - 8 STORE: mem[rd[7:0]]=rs.
  - 9 NOT: rd=~rs.
  - A SHL: rd=rs<<1.
  - B SHR: rd=rs>>1, logical.
  - C–F behave as NOP.
- Arithmetic is modulo 2^16. There are no flags, and carry/borrow is discarded.
- RAM address is the low 8 bits of the address register. Upper bits are ignored, so addresses wrap mod 256.
- State machine, 2-bit `state`, advances every clock: FETCH(0) -> DECODE(1) -> EXECUTE(2) -> WRITEBACK(3) -> FETCH.
  - FETCH: latch `inst` into the instruction register; `op` = IR[15:12].
  - DECODE:
    - lSel = rs for R-type and LOAD; rd for STORE.
    - rSel = rt for R-type; rs for STORE.
    - oSel = rd.
    - Latch l = REG[lSel] and r = REG[rSel].
  - EXECUTE:
    - ALU/immediate ops: o = ALU(l, r) or the immediate.
    - LOAD: a = l[7:0], o = mem[a].
    - STORE: a = l[7:0].
  - WRITEBACK:
    - Register-writing ops: REG[oSel] <= o.
    - STORE: mem[a] <= r.
    - NOP: nothing changes.
- Latency: the result is visible in the register file on the clock after WRITEBACK, i.e. 4 clocks after the FETCH edge.
- An instruction's effects are complete before the next FETCH, so back-to-back dependent instructions need no forwarding. A STORE followed by a LOAD of the same address returns the stored value.
- Writing an instruction to `inst` outside FETCH has no effect on the instruction in flight.
- Reset behaviour:
  - res=1 at a rising edge sets state=FETCH, IR=0 (NOP), l=r=o=0, a=0, and all 8 registers to 0.
  - RAM is not cleared.
  - Reset mid-instruction aborts it; a pending write is not performed.
  - While res is held high, state stays at FETCH.
  - The first FETCH after reset is the first edge with res=0.
- Register 0 is an ordinary writable register.
- Control strobes OINdec/OINreg, LOUTdec/LOUTreg, ROUTdec/ROUTreg, CSdec/CSmem and RW (1=read, 0=write) are internal decode signals:
  - RW=0 and CSmem=1 only in WRITEBACK of STORE.
  - CSmem=1 with RW=1 in EXECUTE of LOAD.
- Verification-visible internal names:
  - `state`, `op`, `l`, `r`, `o`, `a`, `lSel`, `rSel`, `oSel`.
  - The register file instance `REG` with array `ff[0:7]`.

Test Plan:
- Reset: hold res=1 for 2 clocks with inst=0x0000 -> state=0, all REG.ff=0, l=r=o=0. Release res; the NOP cycle leaves everything at 0.
- LOADI: inst=0x6005 (r0=5); then 0x6A0E (r5=14), aligned to FETCH -> after 4 clocks each, REG.ff[0]=0x0005 and REG.ff[5]=0x000E.
- Store/load round trip, for i=0..3:
  - Steps: LOADI ri=i; LOADI r(i+4)=7i; STORE rd=i rs=i+4; LOADI r(i+4)=0.
  - Then, for i=0..3, LOAD rd=i+4 rs=i.
  - Expected: REG.ff[4..7] = 0,7,14,21 and mem[0..3] = 0,7,14,21.
- ALU: r1=0x1FF, r2=1, ADD r3=r1+r2 -> 0x0200. SUB r4=r2-r1 -> 0xFE02. XOR/AND/OR/NOT/SHL/SHR give the correct 16-bit values.
- Wrap: r1=0x1FF, SHL repeated 8 times -> 0xFF80 then 0xFF00 (bits shifted out are lost). An address register value of 0x0105 stores to mem[0x05].
- Mid-instruction reset: assert res during EXECUTE of LOADI r2=9 -> r2 stays 0 and state returns to 0. A later LOAD of an address stored before the reset returns the prior RAM value.
